// File: rtl/aes_pkg.sv
// Shared AES types, constant tables and GF(2^8) helper functions.
// State byte order follows FIPS-197: byte 0 sits in bits [127:120],
// column c holds bytes 4c..4c+3 (row r = byte 4c+r).
package aes_pkg;

  typedef logic [127:0] aes_state_t;
  typedef logic [31:0]  aes_word_t;

  localparam logic [7:0] SBOX [256] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  localparam logic [7:0] RCON [10] = '{
    8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1b, 8'h36
  };

  // Multiply by x in GF(2^8), reduction polynomial 0x11B.
  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  // Round constant lookup; indices past the table yield zero.
  function automatic logic [7:0] rcon_at(input logic [3:0] idx);
    return (idx < 4'd10) ? RCON[idx] : 8'h00;
  endfunction

  function automatic aes_word_t sub_word(input aes_word_t w);
    return {SBOX[w[31:24]], SBOX[w[23:16]], SBOX[w[15:8]], SBOX[w[7:0]]};
  endfunction

  function automatic aes_word_t rot_word(input aes_word_t w);
    return {w[23:0], w[31:24]};
  endfunction

  function automatic aes_state_t sub_bytes(input aes_state_t s);
    aes_state_t r;
    r = '0;
    for (int i = 0; i < 16; i++) r[127-8*i -: 8] = SBOX[s[127-8*i -: 8]];
    return r;
  endfunction

  // Row r rotates left by r columns.
  function automatic aes_state_t shift_rows(input aes_state_t s);
    aes_state_t r;
    r = '0;
    for (int c = 0; c < 4; c++)
      for (int w = 0; w < 4; w++)
        r[127-8*(4*c+w) -: 8] = s[127-8*(4*((c+w)%4)+w) -: 8];
    return r;
  endfunction

  function automatic aes_state_t mix_columns(input aes_state_t s);
    aes_state_t r;
    logic [7:0] a0, a1, a2, a3;
    r = '0;
    for (int c = 0; c < 4; c++) begin
      a0 = s[127-32*c -: 8];
      a1 = s[119-32*c -: 8];
      a2 = s[111-32*c -: 8];
      a3 = s[103-32*c -: 8];
      r[127-32*c -: 8] = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
      r[119-32*c -: 8] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
      r[111-32*c -: 8] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
      r[103-32*c -: 8] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
    end
    return r;
  endfunction

  // One four-word key expansion step: prev is the block of words eight
  // (AES-256) or four (AES-128) positions back, last is the most recent word.
  function automatic aes_state_t key_expand_step(input aes_state_t prev, input aes_word_t last,
                                                 input logic use_rot, input logic [7:0] rcon);
    aes_word_t t, w0, w1, w2, w3;
    t  = use_rot ? (sub_word(rot_word(last)) ^ {rcon, 24'h0}) : sub_word(last);
    w0 = prev[127:96] ^ t;
    w1 = prev[95:64]  ^ w0;
    w2 = prev[63:32]  ^ w1;
    w3 = prev[31:0]   ^ w2;
    return {w0, w1, w2, w3};
  endfunction

endpackage

// File: rtl/aes_round.sv
// Combinational AES round: SubBytes, ShiftRows, optional MixColumns, AddRoundKey.
module aes_round (
  input  logic [127:0] state_i,
  input  logic [127:0] round_key_i,
  input  logic         last_round_i,
  output logic [127:0] next_state_o
);
  import aes_pkg::*;

  logic [127:0] shifted;

  // The final round skips MixColumns.
  always_comb begin
    shifted      = shift_rows(sub_bytes(state_i));
    next_state_o = (last_round_i ? shifted : mix_columns(shifted)) ^ round_key_i;
  end

endmodule

// File: rtl/aes_enc_iter.sv
// Iterative AES-128/256 encryption engine, one round per clock, round keys
// expanded on the fly. Optional macro AES_BLOCK_COUNT_EN adds a 32-bit
// completed-block counter on port blk_count.
//
// Handshake: a transfer happens on a clk_i edge where valid and ready are
// both high; the sender holds data stable until that edge, and ready never
// depends combinationally on valid.
module aes_enc_iter #(
  parameter int KEY_BITS = 256,
  parameter int OUT_REG  = 1
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] plaintext,
  input  logic [255:0] key,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] ciphertext,
  output logic         busy
`ifdef AES_BLOCK_COUNT_EN
  ,
  output logic [31:0]  blk_count
`endif
);
  import aes_pkg::*;

  localparam int         NR   = (KEY_BITS == 128) ? 10 : 14;
  localparam logic [3:0] NR_L = 4'(NR);

  typedef enum logic [1:0] {S_IDLE, S_ROUND, S_DONE} fsm_e;

  fsm_e         fsm_q;
  logic [3:0]   rcnt_q;
  logic [127:0] state_q;
  logic         in_ready_q, out_valid_q, busy_q;
  logic [127:0] round_key, round_out;
  logic         accept, step, last_round;

  assign accept     = in_ready_q && in_valid;
  assign step       = (fsm_q == S_ROUND);
  assign last_round = (rcnt_q == NR_L);

  aes_round u_round (
    .state_i      (state_q),
    .round_key_i  (round_key),
    .last_round_i (last_round),
    .next_state_o (round_out)
  );

  generate
    if (KEY_BITS == 128) begin : g_ks128
      // rk_q holds rk[rcnt-1]; the key for the current round is derived from it.
      logic [127:0] rk_q;
      logic         unused_key_lo;
      assign unused_key_lo = ^key[127:0];
      assign round_key = key_expand_step(rk_q, rk_q[31:0], 1'b1, rcon_at(rcnt_q - 4'd1));

      // Key register: load on accept, advance one round key per round.
      always_ff @(posedge clk_i) begin
        if (rst_i)       rk_q <= '0;
        else if (accept) rk_q <= key[255:128];
        else if (step)   rk_q <= round_key;
      end
    end else begin : g_ks256
      // win_q holds {rk[rcnt-1], rk[rcnt]}; each round slides in rk[rcnt+1].
      logic [255:0] win_q;
      logic [127:0] next_half;
      assign round_key = win_q[127:0];
      // New half uses RotWord+Rcon when rcnt is odd (even expansion step).
      assign next_half = key_expand_step(win_q[255:128], win_q[31:0], rcnt_q[0],
                                         rcon_at((rcnt_q - 4'd1) >> 1));

      // Key window: load on accept, slide one half per round.
      always_ff @(posedge clk_i) begin
        if (rst_i)       win_q <= '0;
        else if (accept) win_q <= key;
        else if (step)   win_q <= {win_q[127:0], next_half};
      end
    end
  endgenerate

  // Control FSM with registered handshake and status outputs.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      fsm_q       <= S_IDLE;
      rcnt_q      <= 4'd0;
      state_q     <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      case (fsm_q)
        S_IDLE: begin
          if (accept) begin
            state_q    <= plaintext ^ key[255:128];
            rcnt_q     <= 4'd1;
            fsm_q      <= S_ROUND;
            in_ready_q <= 1'b0;
            busy_q     <= 1'b1;
          end
        end
        S_ROUND: begin
          state_q <= round_out;
          if (last_round) begin
            rcnt_q      <= 4'd0;
            fsm_q       <= S_DONE;
            busy_q      <= 1'b0;
            out_valid_q <= 1'b1;
          end else begin
            rcnt_q <= rcnt_q + 4'd1;
          end
        end
        S_DONE: begin
          if (out_ready) begin
            fsm_q       <= S_IDLE;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
          end
        end
        default: fsm_q <= S_IDLE;
      endcase
    end
  end

  generate
    if (OUT_REG != 0) begin : g_out_reg
      logic [127:0] ct_q;

      // Capture the final-round result; held until the next block completes.
      always_ff @(posedge clk_i) begin
        if (rst_i)                    ct_q <= '0;
        else if (step && last_round)  ct_q <= round_out;
      end
      assign ciphertext = ct_q;
    end else begin : g_out_comb
      // state_q is frozen while in DONE, so it doubles as the result.
      assign ciphertext = state_q;
    end
  endgenerate

`ifdef AES_BLOCK_COUNT_EN
  logic [31:0] blk_count_q;

  // Count completed output handshakes; wraps naturally at 2^32.
  always_ff @(posedge clk_i) begin
    if (rst_i)                           blk_count_q <= 32'd0;
    else if (out_valid_q && out_ready)   blk_count_q <= blk_count_q + 32'd1;
  end
  assign blk_count = blk_count_q;
`endif

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_aes_enc_iter.sv
// Bench for aes_enc_iter: one AES-128 instance (registered output) and one
// AES-256 instance (unregistered output), checked against FIPS-197 vectors.
module tb_aes_enc_iter;

  localparam logic [127:0] PT_C    = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] KEY_C1  = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] CT_C1   = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [255:0] KEY_C3  = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
  localparam logic [127:0] CT_C3   = 128'h8ea2b7ca516745bfeafc49904b496089;
  localparam logic [127:0] PT_B    = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] KEY_B   = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] CT_B    = 128'h3925841d02dc09fbdc118597196a0b32;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid_a  [2];
  logic         in_ready_a  [2];
  logic [127:0] pt_a        [2];
  logic [255:0] key_a       [2];
  logic         out_valid_a [2];
  logic         out_ready_a [2];
  logic [127:0] ct_a        [2];
  logic         busy_a      [2];
`ifdef AES_BLOCK_COUNT_EN
  logic [31:0]  cnt_a       [2];
`endif

  logic [127:0] exp_q[$];
  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  // Clock and cycle counter
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  aes_enc_iter #(.KEY_BITS(128), .OUT_REG(1)) u_dut128 (
    .clk_i(clk), .rst_i(rst),
    .in_valid(in_valid_a[0]), .in_ready(in_ready_a[0]),
    .plaintext(pt_a[0]), .key(key_a[0]),
    .out_valid(out_valid_a[0]), .out_ready(out_ready_a[0]),
    .ciphertext(ct_a[0]), .busy(busy_a[0])
`ifdef AES_BLOCK_COUNT_EN
    , .blk_count(cnt_a[0])
`endif
  );

  aes_enc_iter #(.KEY_BITS(256), .OUT_REG(0)) u_dut256 (
    .clk_i(clk), .rst_i(rst),
    .in_valid(in_valid_a[1]), .in_ready(in_ready_a[1]),
    .plaintext(pt_a[1]), .key(key_a[1]),
    .out_valid(out_valid_a[1]), .out_ready(out_ready_a[1]),
    .ciphertext(ct_a[1]), .busy(busy_a[1])
`ifdef AES_BLOCK_COUNT_EN
    , .blk_count(cnt_a[1])
`endif
  );

  // ---------------- driver tasks ----------------
  task automatic drive_block(input int sel, input logic [127:0] pt, input logic [255:0] k,
                             output bit ok);
    ok = 1'b0;
    pt_a[sel]       = pt;
    key_a[sel]      = k;
    in_valid_a[sel] = 1'b1;
    for (int n = 0; n < 60; n++) begin
      if (in_ready_a[sel]) begin
        @(posedge clk); #1;
        in_valid_a[sel] = 1'b0;
        ok = 1'b1;
        return;
      end
      @(posedge clk); #1;
    end
    in_valid_a[sel] = 1'b0;
  endtask

  // Counts edges after the accepting edge until out_valid; stops at 40.
  task automatic wait_out(input int sel, output int lat);
    lat = 0;
    while (!out_valid_a[sel] && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic out_handshake(input int sel);
    out_ready_a[sel] = 1'b1;
    @(posedge clk); #1;
    out_ready_a[sel] = 1'b0;
  endtask

  function automatic logic [127:0] junk128();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  // ---------------- tests ----------------
  task automatic test_reset();
    for (int s = 0; s < 2; s++) begin
      total++; if (in_ready_a[s] !== 1'b1) begin bad++; $display("FAIL reset_in_ready[%0d] got=%b want=1", s, in_ready_a[s]); end
      total++; if (out_valid_a[s] !== 1'b0) begin bad++; $display("FAIL reset_out_valid[%0d] got=%b want=0", s, out_valid_a[s]); end
      total++; if (busy_a[s] !== 1'b0) begin bad++; $display("FAIL reset_busy[%0d] got=%b want=0", s, busy_a[s]); end
      total++; if (ct_a[s] !== 128'h0) begin bad++; $display("FAIL reset_ct[%0d] got=%h want=0", s, ct_a[s]); end
`ifdef AES_BLOCK_COUNT_EN
      total++; if (cnt_a[s] !== 32'd0) begin bad++; $display("FAIL reset_cnt[%0d] got=%0d want=0", s, cnt_a[s]); end
`endif
    end
  endtask

  task automatic test_c1();
    bit ok; int lat; logic [127:0] exp;
    exp_q.push_back(CT_C1);
    drive_block(0, PT_C, {KEY_C1, junk128()}, ok);
    total++; if (!ok) begin bad++; $display("FAIL c1_accept got=timeout want=accept"); end
    total++; if (busy_a[0] !== 1'b1 || in_ready_a[0] !== 1'b0) begin bad++; $display("FAIL c1_busy got busy=%b in_ready=%b want 1/0", busy_a[0], in_ready_a[0]); end
    wait_out(0, lat);
    total++; if (lat !== 10) begin bad++; $display("FAIL c1_latency got=%0d want=10", lat); end
    exp = exp_q.pop_front();
    total++; if (ct_a[0] !== exp) begin bad++; $display("FAIL c1_ct got=%h want=%h", ct_a[0], exp); end
    out_handshake(0);
    total++; if (out_valid_a[0] !== 1'b0 || in_ready_a[0] !== 1'b1) begin bad++; $display("FAIL c1_release got out_valid=%b in_ready=%b want 0/1", out_valid_a[0], in_ready_a[0]); end
  endtask

  task automatic test_c3();
    bit ok; int lat; logic [127:0] exp;
    exp_q.push_back(CT_C3);
    drive_block(1, PT_C, KEY_C3, ok);
    total++; if (!ok) begin bad++; $display("FAIL c3_accept got=timeout want=accept"); end
    total++; if (busy_a[1] !== 1'b1) begin bad++; $display("FAIL c3_busy got=%b want=1", busy_a[1]); end
    wait_out(1, lat);
    total++; if (lat !== 14) begin bad++; $display("FAIL c3_latency got=%0d want=14", lat); end
    total++; if (busy_a[1] !== 1'b0) begin bad++; $display("FAIL c3_busy_done got=%b want=0", busy_a[1]); end
    exp = exp_q.pop_front();
    total++; if (ct_a[1] !== exp) begin bad++; $display("FAIL c3_ct got=%h want=%h", ct_a[1], exp); end
    out_handshake(1);
    total++; if (out_valid_a[1] !== 1'b0) begin bad++; $display("FAIL c3_release got=%b want=0", out_valid_a[1]); end
  endtask

  task automatic test_fips_b();
    bit ok; int lat; logic [127:0] exp;
    repeat ($urandom_range(1, 5)) begin @(posedge clk); #1; end
    exp_q.push_back(CT_B);
    drive_block(0, PT_B, {KEY_B, junk128()}, ok);
    total++; if (!ok) begin bad++; $display("FAIL b_accept got=timeout want=accept"); end
    wait_out(0, lat);
    total++; if (lat !== 10) begin bad++; $display("FAIL b_latency got=%0d want=10", lat); end
    exp = exp_q.pop_front();
    total++; if (ct_a[0] !== exp) begin bad++; $display("FAIL b_ct got=%h want=%h", ct_a[0], exp); end
    out_handshake(0);
  endtask

  task automatic test_backpressure();
    bit ok; int lat; logic [127:0] exp;
    exp_q.push_back(CT_C1);
    drive_block(0, PT_C, {KEY_C1, junk128()}, ok);
    total++; if (!ok) begin bad++; $display("FAIL bp_accept got=timeout want=accept"); end
    wait_out(0, lat);
    total++; if (lat !== 10) begin bad++; $display("FAIL bp_latency got=%0d want=10", lat); end
    exp = exp_q.pop_front();
    // Offer the next block while the output is stalled; it must be ignored.
    pt_a[0]       = PT_B;
    key_a[0]      = {KEY_B, junk128()};
    in_valid_a[0] = 1'b1;
    for (int i = 0; i < 20; i++) begin
      total++; if (ct_a[0] !== exp) begin bad++; $display("FAIL bp_ct_hold cycle=%0d got=%h want=%h", i, ct_a[0], exp); end
      total++; if (in_ready_a[0] !== 1'b0 || out_valid_a[0] !== 1'b1) begin bad++; $display("FAIL bp_flags cycle=%0d got in_ready=%b out_valid=%b want 0/1", i, in_ready_a[0], out_valid_a[0]); end
      @(posedge clk); #1;
    end
    out_ready_a[0] = 1'b1;
    @(posedge clk); #1;
    out_ready_a[0] = 1'b0;
    total++; if (out_valid_a[0] !== 1'b0 || in_ready_a[0] !== 1'b1 || busy_a[0] !== 1'b0) begin bad++; $display("FAIL bp_after_hs got out_valid=%b in_ready=%b busy=%b want 0/1/0", out_valid_a[0], in_ready_a[0], busy_a[0]); end
    exp_q.push_back(CT_B);
    @(posedge clk); #1;
    in_valid_a[0] = 1'b0;
    total++; if (busy_a[0] !== 1'b1 || in_ready_a[0] !== 1'b0) begin bad++; $display("FAIL bp_second_accept got busy=%b in_ready=%b want 1/0", busy_a[0], in_ready_a[0]); end
    wait_out(0, lat);
    total++; if (lat !== 10) begin bad++; $display("FAIL bp2_latency got=%0d want=10", lat); end
    exp = exp_q.pop_front();
    total++; if (ct_a[0] !== exp) begin bad++; $display("FAIL bp2_ct got=%h want=%h", ct_a[0], exp); end
    out_handshake(0);
  endtask

  task automatic test_reset_mid_round();
    bit ok; int lat; int seen; logic [127:0] exp;
    drive_block(0, PT_C, {KEY_C1, junk128()}, ok);
    total++; if (!ok) begin bad++; $display("FAIL mid_accept got=timeout want=accept"); end
    repeat (4) begin @(posedge clk); #1; end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    total++; if (in_ready_a[0] !== 1'b1 || out_valid_a[0] !== 1'b0 || busy_a[0] !== 1'b0) begin bad++; $display("FAIL mid_reset_flags got in_ready=%b out_valid=%b busy=%b want 1/0/0", in_ready_a[0], out_valid_a[0], busy_a[0]); end
    total++; if (ct_a[0] !== 128'h0) begin bad++; $display("FAIL mid_reset_ct got=%h want=0", ct_a[0]); end
    seen = 0;
    repeat (16) begin @(posedge clk); #1; if (out_valid_a[0]) seen++; end
    total++; if (seen !== 0) begin bad++; $display("FAIL mid_no_output got=%0d want=0", seen); end
    exp_q.push_back(CT_C1);
    drive_block(0, PT_C, {KEY_C1, junk128()}, ok);
    wait_out(0, lat);
    total++; if (lat !== 10) begin bad++; $display("FAIL mid_latency got=%0d want=10", lat); end
    exp = exp_q.pop_front();
    total++; if (ct_a[0] !== exp) begin bad++; $display("FAIL mid_ct got=%h want=%h", ct_a[0], exp); end
    out_handshake(0);
  endtask

  task automatic test_back_to_back();
    bit ok; int lat; int t_prev; int t_now; logic [127:0] exp;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
`ifdef AES_BLOCK_COUNT_EN
    total++; if (cnt_a[0] !== 32'd0) begin bad++; $display("FAIL b2b_cnt_reset got=%0d want=0", cnt_a[0]); end
`endif
    out_ready_a[0] = 1'b1;
    t_prev = 0;
    for (int i = 0; i < 3; i++) begin
      exp_q.push_back(CT_C1);
      drive_block(0, PT_C, {KEY_C1, junk128()}, ok);
      t_now = cyc;
      total++; if (!ok) begin bad++; $display("FAIL b2b_accept blk=%0d got=timeout want=accept", i); end
      if (i > 0) begin
        total++; if (t_now - t_prev !== 12) begin bad++; $display("FAIL b2b_period blk=%0d got=%0d want=12", i, t_now - t_prev); end
      end
      t_prev = t_now;
      wait_out(0, lat);
      total++; if (lat !== 10) begin bad++; $display("FAIL b2b_latency blk=%0d got=%0d want=10", i, lat); end
      exp = exp_q.pop_front();
      total++; if (ct_a[0] !== exp) begin bad++; $display("FAIL b2b_ct blk=%0d got=%h want=%h", i, ct_a[0], exp); end
      @(posedge clk); #1;
      total++; if (out_valid_a[0] !== 1'b0 || in_ready_a[0] !== 1'b1) begin bad++; $display("FAIL b2b_release blk=%0d got out_valid=%b in_ready=%b want 0/1", i, out_valid_a[0], in_ready_a[0]); end
`ifdef AES_BLOCK_COUNT_EN
      total++; if (cnt_a[0] !== 32'(i + 1)) begin bad++; $display("FAIL b2b_cnt blk=%0d got=%0d want=%0d", i, cnt_a[0], i + 1); end
`endif
    end
    out_ready_a[0] = 1'b0;
  endtask

  // Main sequence
  initial begin
    rst = 1'b1;
    for (int s = 0; s < 2; s++) begin
      in_valid_a[s]  = 1'b0;
      out_ready_a[s] = 1'b0;
      pt_a[s]        = '0;
      key_a[s]       = '0;
    end
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    test_reset();
    test_c1();
    test_c3();
    test_fips_b();
    test_backpressure();
    test_reset_mid_round();
    test_back_to_back();
    total++; if (exp_q.size() !== 0) begin bad++; $display("FAIL scoreboard_leftover got=%0d want=0", exp_q.size()); end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Guard against a hang anywhere above.
  initial begin
    #200000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
